// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard control for the 4-stage core: operand forwarding, load-use interlock,
// jump flush penalty, and halt detection with cycle/retire counters.
module pipe_hazard_unit #(
   parameter int unsigned DW         = 32,
   parameter int unsigned RW         = 5,
   parameter int unsigned FWD_DEPTH  = 2,
   parameter int unsigned LOAD_LAT   = 1,
   parameter int unsigned BR_PENALTY = 1,
   parameter logic [5:0]  HALT_OP    = 6'b111111
) (
   input  logic          sysclk,
   input  logic          cpu_resetn,
   input  logic [RW-1:0] rs_d,
   input  logic [RW-1:0] rt_d,
   input  logic          use_rs_d,
   input  logic          use_rt_d,
   input  logic          is_load_e,
   input  logic [RW-1:0] wreg_e,
   input  logic          jump_e,
   input  logic [RW-1:0] rs_e,
   input  logic [RW-1:0] rt_e,
   input  logic [DW-1:0] os_e_in,
   input  logic [DW-1:0] ot_e_in,
   input  logic          valid_w,
   input  logic [5:0]    op_w,
   input  logic [RW-1:0] wreg_w,
   input  logic [DW-1:0] wdata_w,
   output logic [DW-1:0] os_e_out,
   output logic [DW-1:0] ot_e_out,
   output logic          stall_f,
   output logic          stall_d,
   output logic          bubble_e,
   output logic          flush_fd,
   output logic          halted,
   output logic [DW-1:0] cycle_count,
   output logic [DW-1:0] retired_count
);

   localparam int unsigned HD = (FWD_DEPTH > 1) ? FWD_DEPTH - 1 : 1;
   localparam int unsigned CW = 2;
   localparam logic [CW-1:0] LD_INIT = CW'(LOAD_LAT - 1);
   localparam logic [CW-1:0] BR_INIT = CW'(BR_PENALTY - 1);

   localparam logic [1:0] RUN    = 2'd0;
   localparam logic [1:0] LSTALL = 2'd1;
   localparam logic [1:0] FLUSH  = 2'd2;
   localparam logic [1:0] HALT   = 2'd3;

   logic [1:0]    state, state_nxt;
   logic [CW-1:0] ld_cnt, ld_nxt;
   logic [CW-1:0] br_cnt, br_nxt;
   logic          hazard, halt_trig, w_match_ok;

   logic          hist_v [HD];
   logic [RW-1:0] hist_r [HD];
   logic [DW-1:0] hist_d [HD];

   assign w_match_ok = valid_w && (wreg_w != '0);
   assign halt_trig  = valid_w && (op_w == HALT_OP);
   assign hazard     = is_load_e && (wreg_e != '0) &&
                       ((use_rs_d && (rs_d == wreg_e)) || (use_rt_d && (rt_d == wreg_e)));

   // State and penalty counters
   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         state  <= RUN;
         ld_cnt <= '0;
         br_cnt <= '0;
         halted <= 1'b0;
      end else begin
         state  <= state_nxt;
         ld_cnt <= ld_nxt;
         br_cnt <= br_nxt;
         halted <= (state_nxt == HALT);
      end
   end

   // Penalty counters hold the number of extra cycles beyond the trigger cycle
   always_comb begin
      state_nxt = state;
      ld_nxt    = ld_cnt;
      br_nxt    = br_cnt;
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      bubble_e  = 1'b0;
      flush_fd  = 1'b0;
      case (state)
         RUN: begin
            if (jump_e) begin
               flush_fd = 1'b1;
               br_nxt   = BR_INIT;
               if (BR_INIT != '0) state_nxt = FLUSH;
            end else if (hazard) begin
               stall_f  = 1'b1;
               stall_d  = 1'b1;
               bubble_e = 1'b1;
               ld_nxt   = LD_INIT;
               if (LD_INIT != '0) state_nxt = LSTALL;
            end
         end
         LSTALL: begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            bubble_e = 1'b1;
            ld_nxt   = ld_cnt - CW'(1);
            if (ld_cnt == CW'(1)) state_nxt = RUN;
         end
         FLUSH: begin
            flush_fd = 1'b1;
            if (jump_e) begin
               br_nxt = BR_INIT;
               if (BR_INIT == '0) state_nxt = RUN;
            end else begin
               br_nxt = br_cnt - CW'(1);
               if (br_cnt == CW'(1)) state_nxt = RUN;
            end
         end
         HALT: begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            bubble_e = 1'b1;
         end
         default: state_nxt = RUN;
      endcase
      if (halt_trig) state_nxt = HALT;
   end

   // Write-back history; frozen once halted
   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         for (int i = 0; i < int'(HD); i++) begin
            hist_v[i] <= 1'b0;
            hist_r[i] <= '0;
            hist_d[i] <= '0;
         end
      end else if (state != HALT) begin
         hist_v[0] <= w_match_ok;
         hist_r[0] <= wreg_w;
         hist_d[0] <= wdata_w;
         for (int i = 1; i < int'(HD); i++) begin
            hist_v[i] <= hist_v[i-1];
            hist_r[i] <= hist_r[i-1];
            hist_d[i] <= hist_d[i-1];
         end
      end
   end

   // Oldest first so younger matches overwrite; current write-stage result wins last
   always_comb begin
      os_e_out = os_e_in;
      ot_e_out = ot_e_in;
      if (FWD_DEPTH > 1) begin
         for (int i = int'(HD) - 1; i >= 0; i--) begin
            if (hist_v[i] && (hist_r[i] == rs_e)) os_e_out = hist_d[i];
            if (hist_v[i] && (hist_r[i] == rt_e)) ot_e_out = hist_d[i];
         end
      end
      if (w_match_ok && (wreg_w == rs_e)) os_e_out = wdata_w;
      if (w_match_ok && (wreg_w == rt_e)) ot_e_out = wdata_w;
   end

   // Cycle and retire counters, frozen in HALT
   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         cycle_count   <= '0;
         retired_count <= '0;
      end else if (state != HALT) begin
         cycle_count <= cycle_count + DW'(1);
         if (valid_w) retired_count <= retired_count + DW'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: directed stimulus pushes expectations,
// a monitor drains and compares them on the falling edge or on demand.
module tb_pipe_hazard_unit;

   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;

   localparam int S_OS = 0, S_OT = 1, S_SF = 2, S_SD = 3, S_BE = 4, S_FL = 5;
   localparam int S_HALT = 6, S_CYC = 7, S_RET = 8, S_WCYC = 9, S_WMISC = 10;

   logic sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   logic          cpu_resetn, wrap_resetn;
   logic [RW-1:0] rs_d, rt_d, wreg_e, rs_e, rt_e, wreg_w;
   logic          use_rs_d, use_rt_d, is_load_e, jump_e, valid_w;
   logic [5:0]    op_w;
   logic [DW-1:0] os_e_in, ot_e_in, wdata_w;
   logic [DW-1:0] os_e_out, ot_e_out, cycle_count, retired_count;
   logic          stall_f, stall_d, bubble_e, flush_fd, halted;

   logic [3:0]    w_os, w_ot, w_cyc, w_ret;
   logic          w_sf, w_sd, w_be, w_fl, w_h;
   logic          wrap_misc;
   assign wrap_misc = |{w_os, w_ot, w_ret, w_sf, w_sd, w_be, w_fl, w_h};

   pipe_hazard_unit #(.DW(DW), .RW(RW), .FWD_DEPTH(2), .LOAD_LAT(2), .BR_PENALTY(2),
                      .HALT_OP(6'b111111)) dut (
      .sysclk(sysclk), .cpu_resetn(cpu_resetn),
      .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
      .is_load_e(is_load_e), .wreg_e(wreg_e), .jump_e(jump_e),
      .rs_e(rs_e), .rt_e(rt_e), .os_e_in(os_e_in), .ot_e_in(ot_e_in),
      .valid_w(valid_w), .op_w(op_w), .wreg_w(wreg_w), .wdata_w(wdata_w),
      .os_e_out(os_e_out), .ot_e_out(ot_e_out),
      .stall_f(stall_f), .stall_d(stall_d), .bubble_e(bubble_e), .flush_fd(flush_fd),
      .halted(halted), .cycle_count(cycle_count), .retired_count(retired_count)
   );

   pipe_hazard_unit #(.DW(4), .RW(RW)) u_wrap (
      .sysclk(sysclk), .cpu_resetn(wrap_resetn),
      .rs_d('0), .rt_d('0), .use_rs_d(1'b0), .use_rt_d(1'b0),
      .is_load_e(1'b0), .wreg_e('0), .jump_e(1'b0),
      .rs_e('0), .rt_e('0), .os_e_in(4'h0), .ot_e_in(4'h0),
      .valid_w(1'b0), .op_w(6'h0), .wreg_w('0), .wdata_w(4'h0),
      .os_e_out(w_os), .ot_e_out(w_ot),
      .stall_f(w_sf), .stall_d(w_sd), .bubble_e(w_be), .flush_fd(w_fl),
      .halted(w_h), .cycle_count(w_cyc), .retired_count(w_ret)
   );

   typedef struct {
      string       name;
      int          sig;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   event chk_ev;

   function automatic logic [31:0] actual(int sig);
      case (sig)
         S_OS:    return os_e_out;
         S_OT:    return ot_e_out;
         S_SF:    return 32'(stall_f);
         S_SD:    return 32'(stall_d);
         S_BE:    return 32'(bubble_e);
         S_FL:    return 32'(flush_fd);
         S_HALT:  return 32'(halted);
         S_CYC:   return cycle_count;
         S_RET:   return retired_count;
         S_WCYC:  return 32'(w_cyc);
         S_WMISC: return 32'(wrap_misc);
         default: return 32'hdead_beef;
      endcase
   endfunction

   // Monitor: compares every queued expectation against the live outputs
   always @(negedge sysclk or chk_ev) begin
      exp_t e;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         n_checks++;
         if (actual(e.sig) === e.exp) n_pass++;
         else $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, actual(e.sig), e.exp);
      end
   end

   task automatic expect_val(input string name, input int sig, input logic [31:0] v);
      exp_t e;
      e.name = name;
      e.sig  = sig;
      e.exp  = v;
      sb.push_back(e);
   endtask

   task automatic expect_ctl(input string name, input logic sf, input logic sd,
                             input logic be, input logic fl);
      expect_val({name, ".stall_f"},  S_SF, 32'(sf));
      expect_val({name, ".stall_d"},  S_SD, 32'(sd));
      expect_val({name, ".bubble_e"}, S_BE, 32'(be));
      expect_val({name, ".flush_fd"}, S_FL, 32'(fl));
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic clear_inputs();
      rs_d = '0; rt_d = '0; use_rs_d = 1'b0; use_rt_d = 1'b0;
      is_load_e = 1'b0; wreg_e = '0; jump_e = 1'b0;
      rs_e = '0; rt_e = '0; os_e_in = '0; ot_e_in = '0;
      valid_w = 1'b0; op_w = '0; wreg_w = '0; wdata_w = '0;
   endtask

   initial begin
      cpu_resetn  = 1'b0;
      wrap_resetn = 1'b0;
      clear_inputs();

      tick();
      expect_ctl("reset", 0, 0, 0, 0);
      expect_val("reset.halted", S_HALT, 0);
      expect_val("reset.cycle", S_CYC, 0);
      expect_val("reset.retired", S_RET, 0);
      tick();
      cpu_resetn = 1'b1;

      // Forwarding
      tick();
      valid_w = 1; wreg_w = 3; wdata_w = 32'h11; rs_e = 3; os_e_in = 32'h5;
      rt_e = 4; ot_e_in = 32'h77;
      expect_val("fwd_first", S_OS, 32'h11);
      expect_val("fwd_nomatch_rt", S_OT, 32'h77);
      tick();
      wdata_w = 32'h22;
      expect_val("fwd_youngest", S_OS, 32'h22);
      tick();
      valid_w = 0;
      expect_val("fwd_hist", S_OS, 32'h22);
      tick();
      valid_w = 1; wreg_w = 0; wdata_w = 32'h33; rs_e = 0; rt_e = 3; ot_e_in = 32'h44;
      expect_val("fwd_r0", S_OS, 32'h5);
      expect_val("fwd_hist_invalid", S_OT, 32'h44);
      tick();
      wreg_w = 4; wdata_w = 32'h55; rs_e = 4; rt_e = 4;
      expect_val("fwd_both_rs", S_OS, 32'h55);
      expect_val("fwd_both_rt", S_OT, 32'h55);
      tick();
      clear_inputs();
      expect_ctl("idle", 0, 0, 0, 0);

      // Load-use interlock
      tick();
      is_load_e = 1; wreg_e = 7; rs_d = 7; use_rs_d = 1;
      expect_ctl("lu_hazard", 1, 1, 1, 0);
      tick();
      is_load_e = 0;
      expect_ctl("lu_stall2", 1, 1, 1, 0);
      tick();
      expect_ctl("lu_done", 0, 0, 0, 0);
      tick();
      is_load_e = 1; use_rs_d = 0; rt_d = 7; use_rt_d = 0;
      expect_ctl("lu_unused", 0, 0, 0, 0);
      tick();
      use_rt_d = 1;
      expect_ctl("lu_rt", 1, 1, 1, 0);
      tick();
      is_load_e = 0;
      expect_ctl("lu_rt_stall2", 1, 1, 1, 0);
      tick();
      expect_ctl("lu_rt_done", 0, 0, 0, 0);
      tick();
      is_load_e = 1; wreg_e = 0; rs_d = 0; use_rs_d = 1; rt_d = 0; use_rt_d = 0;
      expect_ctl("lu_r0", 0, 0, 0, 0);

      // Jump flush
      tick();
      clear_inputs(); jump_e = 1;
      expect_ctl("jmp", 0, 0, 0, 1);
      tick();
      jump_e = 0;
      expect_ctl("jmp_pen", 0, 0, 0, 1);
      tick();
      expect_ctl("jmp_done", 0, 0, 0, 0);
      tick();
      jump_e = 1; is_load_e = 1; wreg_e = 7; rs_d = 7; use_rs_d = 1;
      expect_ctl("jmp_vs_lu", 0, 0, 0, 1);
      tick();
      clear_inputs();
      expect_ctl("jmp_vs_lu_pen", 0, 0, 0, 1);
      tick();
      expect_ctl("jmp_vs_lu_done", 0, 0, 0, 0);
      tick();
      jump_e = 1;
      expect_ctl("jmp_a", 0, 0, 0, 1);
      tick();
      expect_ctl("jmp_reload", 0, 0, 0, 1);
      tick();
      jump_e = 0;
      expect_ctl("jmp_reload_pen", 0, 0, 0, 1);
      tick();
      expect_ctl("jmp_reload_done", 0, 0, 0, 0);

      // Reset in the middle of a load stall
      tick();
      is_load_e = 1; wreg_e = 7; rs_d = 7; use_rs_d = 1;
      valid_w = 1; wreg_w = 9; wdata_w = 32'h99; rs_e = 9; os_e_in = 32'habc;
      expect_ctl("rst_hazard", 1, 1, 1, 0);
      expect_val("rst_fwd_now", S_OS, 32'h99);
      tick();
      is_load_e = 0; valid_w = 0;
      expect_ctl("rst_pre_stall", 1, 1, 1, 0);
      expect_val("rst_pre_fwd", S_OS, 32'h99);
      #1;
      -> chk_ev;
      #1;
      cpu_resetn = 1'b0;
      #1;
      expect_ctl("rst_mid", 0, 0, 0, 0);
      expect_val("rst_mid_hist", S_OS, 32'habc);
      expect_val("rst_mid_halted", S_HALT, 0);
      expect_val("rst_mid_cycle", S_CYC, 0);
      expect_val("rst_mid_retired", S_RET, 0);
      -> chk_ev;

      // Halt after 10 valid cycles plus the halting one
      tick();
      cpu_resetn = 1'b1;
      valid_w = 1; op_w = 6'h0; wreg_w = 0;
      expect_val("post_rst_fwd", S_OS, 32'habc);
      expect_ctl("post_rst", 0, 0, 0, 0);
      expect_val("post_rst_cycle", S_CYC, 0);
      for (int k = 2; k <= 10; k++) begin
         tick();
         if (k == 6) begin
            expect_val("run_cycle", S_CYC, 5);
            expect_val("run_retired", S_RET, 5);
         end
      end
      tick();
      op_w = 6'b111111; wreg_w = 6; wdata_w = 32'h66;
      expect_val("halt_trig_halted", S_HALT, 0);
      expect_val("halt_trig_cycle", S_CYC, 10);
      expect_val("halt_trig_retired", S_RET, 10);
      expect_ctl("halt_trig", 0, 0, 0, 0);
      tick();
      op_w = 6'h0; wreg_w = 0; rs_e = 6; os_e_in = 32'h1; jump_e = 1;
      expect_val("halted", S_HALT, 1);
      expect_ctl("halt_ctl", 1, 1, 1, 0);
      expect_val("halt_cycle", S_CYC, 11);
      expect_val("halt_retired", S_RET, 11);
      expect_val("halt_hist", S_OS, 32'h66);
      tick();
      expect_val("halt_hold", S_HALT, 1);
      expect_val("halt_cycle_frozen", S_CYC, 11);
      expect_val("halt_retired_frozen", S_RET, 11);
      expect_val("halt_hist_frozen", S_OS, 32'h66);

      // Counter wrap on the 4-bit instance
      tick();
      wrap_resetn = 1'b1;
      expect_val("wrap_start", S_WCYC, 0);
      repeat (15) tick();
      expect_val("wrap_15", S_WCYC, 15);
      tick();
      expect_val("wrap_0", S_WCYC, 0);
      expect_val("wrap_idle", S_WMISC, 0);
      tick();
      expect_val("wrap_1", S_WCYC, 1);

      @(negedge sysclk);
      #1;
      if (sb.size() != 0) begin
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
         n_checks += sb.size();
         sb.delete();
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
